// File: rtl/bcd_to_binary_converter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_converter
// Description : Sequential packed-BCD to unsigned binary converter using
//               reverse double-dabble: one right shift plus a subtract-3
//               correction of every BCD field per clock, OUT_W iterations.
// Ports       :
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   conversion request, sampled only while idle
//   bcd_in   in   packed BCD, digit 0 (units) in bits [3:0]
//   busy     out  high while a conversion is running
//   done     out  one-cycle pulse when bin_out / err are updated
//   err      out  set with done when an input digit was > 9
//   bin_out  out  converted binary value, held until next good conversion
// Revision    : 1.0  initial release
// ============================================================================
module bcd_to_binary_converter #(
   parameter int DIGITS = 4,
   parameter int OUT_W  = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [OUT_W-1:0]      bin_out
);

   localparam int c_BCD_W  = 4 * DIGITS;
   localparam int c_WORK_W = c_BCD_W + OUT_W;
   localparam int c_CNT_W  = $clog2(OUT_W + 1);
   localparam logic [c_CNT_W-1:0] c_COUNT_INIT = c_CNT_W'(OUT_W);
   localparam logic [c_CNT_W-1:0] c_COUNT_LAST = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t                r_state;
   logic [c_WORK_W-1:0]   r_work;
   logic [c_CNT_W-1:0]    r_count;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic [OUT_W-1:0]      r_bin;

   state_t                w_state_nx;
   logic [c_WORK_W-1:0]   w_work_nx;
   logic [c_CNT_W-1:0]    w_count_nx;
   logic                  w_busy_nx;
   logic                  w_done_nx;
   logic                  w_err_nx;
   logic [OUT_W-1:0]      w_bin_nx;

   logic [c_WORK_W-1:0]   w_shifted;
   logic [c_WORK_W-1:0]   w_corrected;
   logic [DIGITS-1:0]     w_digit_bad;
   logic                  w_any_bad;

   // One iteration: the BCD field and the binary field shift right together,
   // so the LSB of each decimal digit moves into the binary accumulator.
   assign w_shifted = r_work >> 1;
   assign w_corrected[OUT_W-1:0] = w_shifted[OUT_W-1:0];

   // A digit that reads >= 8 after the shift received a borrowed "ten" from
   // the digit above worth 8 instead of 5; subtracting 3 restores it. The
   // field can only hold 8..12 here, so the subtraction never underflows.
   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         logic [3:0] w_field;
         assign w_field = w_shifted[OUT_W + 4*k +: 4];
         assign w_corrected[OUT_W + 4*k +: 4] =
            (w_field >= 4'd8) ? (w_field - 4'd3) : w_field;
         assign w_digit_bad[k] = (bcd_in[4*k +: 4] > 4'd9);
      end
   endgenerate

   assign w_any_bad = |w_digit_bad;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_bin   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_work  <= w_work_nx;
         r_count <= w_count_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
         r_bin   <= w_bin_nx;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nx = r_state;
      w_work_nx  = r_work;
      w_count_nx = r_count;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;
      w_err_nx   = r_err;
      w_bin_nx   = r_bin;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_any_bad) begin
                  // Rejected request: report through done/err, keep result.
                  w_err_nx  = 1'b1;
                  w_done_nx = 1'b1;
               end else begin
                  w_work_nx  = {bcd_in, {OUT_W{1'b0}}};
                  w_count_nx = c_COUNT_INIT;
                  w_err_nx   = 1'b0;
                  w_busy_nx  = 1'b1;
                  w_state_nx = S_CONV;
               end
            end
         end

         S_CONV: begin
            w_work_nx  = w_corrected;
            w_count_nx = r_count - c_COUNT_LAST;
            if (r_count == c_COUNT_LAST) begin
               w_bin_nx   = w_corrected[OUT_W-1:0];
               w_done_nx  = 1'b1;
               w_busy_nx  = 1'b0;
               w_state_nx = S_FIN;
            end
         end

         S_FIN: begin
            w_state_nx = S_IDLE;
         end

         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;
   assign bin_out = r_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_binary_converter
// Description : Self-checking bench for bcd_to_binary_converter. Expected
//               values come from a decimal-arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_to_binary_converter;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] bcd_in;
   logic        busy;
   logic        done;
   logic        err;
   logic [13:0] bin_out;

   int vectors;
   int miscompares;
   logic [13:0] exp_bin;   // model of the value bin_out should be holding

   bcd_to_binary_converter #(.DIGITS(4), .OUT_W(14)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .bin_out (bin_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain decimal weighting of the digits
   function automatic int ref_value(input logic [15:0] b);
      int v;
      v = 0;
      for (int k = 3; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
      return v;
   endfunction

   function automatic bit ref_valid(input logic [15:0] b);
      for (int k = 0; k < 4; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [15:0] rand_valid_bcd();
      logic [15:0] b;
      for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one conversion and observe it; returns -1 latency on timeout.
   task automatic run_conv(input logic [15:0] b, output int lat, output int bcyc,
                           output logic [13:0] res, output logic e,
                           output logic [15:0] fld, output logic done_after);
      bcd_in = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      bcd_in = 16'($urandom);
      lat = -1; bcyc = 0; res = 'x; e = 'x; fld = 'x; done_after = 'x;
      for (int n = 0; n <= 40; n++) begin
         if (done) begin
            lat = n; res = bin_out; e = err; fld = dut.r_work[29:14];
            break;
         end
         if (busy) bcyc++;
         tick();
      end
      if (lat >= 0) begin
         tick();
         done_after = done;
      end
   endtask

   task automatic check_conv(input string nm, input logic [15:0] b);
      int lat, bcyc;
      logic [13:0] res;
      logic e, da;
      logic [15:0] fld;
      logic [13:0] want;
      want = 14'(ref_value(b));
      run_conv(b, lat, bcyc, res, e, fld, da);
      vectors++;
      if (lat !== 14) begin
         miscompares++;
         $display("FAIL %s latency: got %0d, want 14", nm, lat);
      end
      vectors++;
      if (res !== want) begin
         miscompares++;
         $display("FAIL %s bin_out: got %0d, want %0d", nm, res, want);
      end
      vectors++;
      if (bcyc !== 14) begin
         miscompares++;
         $display("FAIL %s busy cycles: got %0d, want 14", nm, bcyc);
      end
      vectors++;
      if (e !== 1'b0) begin
         miscompares++;
         $display("FAIL %s err at done: got %b, want 0", nm, e);
      end
      vectors++;
      if (fld !== 16'h0000) begin
         miscompares++;
         $display("FAIL %s residual bcd field: got %h, want 0000", nm, fld);
      end
      vectors++;
      if (da !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done width: got done=%b after pulse, want 0", nm, da);
      end
      exp_bin = want;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; bcd_in = 16'h0132;
      tick(); tick();
      vectors++;
      if ({busy, done, err, bin_out} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset outputs: got busy=%b done=%b err=%b bin=%0d, want all 0",
                  busy, done, err, bin_out);
      end
      reset = 1'b0; start = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset start-ignored: got busy=%b, want 0", busy);
      end
      exp_bin = '0;
   endtask

   task automatic test_basic();
      check_conv("basic_0132", 16'h0132);
   endtask

   task automatic test_boundaries();
      logic [15:0] tbl[3] = '{16'h9999, 16'h0000, 16'h0255};
      foreach (tbl[i]) check_conv($sformatf("bound_%h", tbl[i]), tbl[i]);
   endtask

   task automatic test_invalid();
      logic [13:0] prev;
      prev = exp_bin;
      bcd_in = 16'h0A12; start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if ({busy, done, err} !== 3'b011 || bin_out !== prev) begin
         miscompares++;
         $display("FAIL invalid response: got busy=%b done=%b err=%b bin=%0d, want 0 1 1 %0d",
                  busy, done, err, bin_out, prev);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL invalid hold: got done=%b err=%b, want 0 1", done, err);
      end
      check_conv("after_invalid_0100", 16'h0100);
   endtask

   task automatic test_ignore_start();
      int pulses, first;
      logic [13:0] res;
      bcd_in = 16'h1234; start = 1'b1;
      tick();
      start = 1'b0;
      pulses = 0; first = -1; res = 'x;
      for (int n = 0; n < 40; n++) begin
         if (n == 4) begin bcd_in = 16'h5678; start = 1'b1; end
         if (n == 5) start = 1'b0;
         if (done) begin
            pulses++;
            if (first < 0) begin first = n; res = bin_out; end
         end
         tick();
      end
      vectors++;
      if (res !== 14'(ref_value(16'h1234)) || first !== 14) begin
         miscompares++;
         $display("FAIL ignore_start result: got %0d at cycle %0d, want 1234 at 14", res, first);
      end
      vectors++;
      if (pulses !== 1) begin
         miscompares++;
         $display("FAIL ignore_start pulses: got %0d, want 1", pulses);
      end
      exp_bin = 14'(ref_value(16'h1234));
   endtask

   task automatic test_mid_reset();
      int pulses;
      bcd_in = 16'h0999; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 6; n++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({busy, done, bin_out} !== 16'h0) begin
         miscompares++;
         $display("FAIL mid_reset outputs: got busy=%b done=%b bin=%0d, want 0 0 0",
                  busy, done, bin_out);
      end
      exp_bin = '0;
      pulses = 0;
      for (int n = 0; n < 20; n++) begin
         if (done || busy) pulses++;
         tick();
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL mid_reset activity: got %0d active cycles, want 0", pulses);
      end
      check_conv("after_reset_0011", 16'h0011);
   endtask

   task automatic test_back_to_back();
      logic [15:0] seq[4] = '{16'h0132, 16'h0100, 16'h0255, 16'h0000};
      foreach (seq[i]) check_conv($sformatf("b2b_%h", seq[i]), seq[i]);
   endtask

   task automatic test_random();
      logic [15:0] b;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            b = rand_valid_bcd();
            b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
         end else begin
            b = rand_valid_bcd();
         end
         if (ref_valid(b)) begin
            check_conv($sformatf("rand_%h", b), b);
         end else begin
            bcd_in = b; start = 1'b1;
            tick();
            start = 1'b0;
            vectors++;
            if ({busy, done, err} !== 3'b011 || bin_out !== exp_bin) begin
               miscompares++;
               $display("FAIL rand_invalid_%h: got busy=%b done=%b err=%b bin=%0d, want 0 1 1 %0d",
                        b, busy, done, err, bin_out, exp_bin);
            end
            tick();
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      exp_bin = '0;
      reset = 1'b1; start = 1'b0; bcd_in = '0;
      test_reset();
      test_basic();
      test_boundaries();
      test_invalid();
      test_ignore_start();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
